// File: rtl/regfile_scb.sv
// ============================================================================
// Module   : regfile_scb
// Brief    : Multi-read-port register file with write bypass and a per-register
//            pending scoreboard (issue marks a destination busy, write clears it).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scb #(
    parameter  int WIDTH    = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS),
    localparam int CW       = $clog2(NREGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 issue,
    input  logic [AW-1:0]        iaddr,
    output logic                 issue_ok,
    output logic [CW-1:0]        pend_cnt
);

    localparam logic [AW:0] c_nregs_ext = (AW + 1)'(NREGS);

    logic [WIDTH-1:0] r_rf [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [CW-1:0]    r_cnt;

    logic             w_we_ok;
    logic             w_issue_ok;
    logic             w_iss_en;
    logic [NREGS-1:0] w_pend_nxt;
    logic [CW-1:0]    w_cnt_nxt;

    // Addresses past the last register only exist when NREGS is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < c_nregs_ext);
    endfunction

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_we_ok    = we && addr_ok(waddr) && !is_zero(waddr);
    // A write landing on the same register this cycle resolves the WAW hazard.
    assign w_issue_ok = !(addr_ok(iaddr) && r_pend[iaddr] && !(we && (waddr == iaddr)));
    assign w_iss_en   = issue && w_issue_ok && addr_ok(iaddr) && !is_zero(iaddr);
    assign issue_ok   = w_issue_ok;
    assign pend_cnt   = r_cnt;

    // Clear first, then set, so a same-register issue wins over the write.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_we_ok) begin
            w_pend_nxt[waddr] = 1'b0;
        end
        if (w_iss_en) begin
            w_pend_nxt[iaddr] = 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int k = 0; k < NREGS; k++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_pend_nxt[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_rf[k] <= '0;
            end
            r_pend <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_we_ok) begin
                r_rf[waddr] <= wdata;
            end
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;
        logic          w_live;

        assign w_ra   = raddr[g*AW +: AW];
        assign w_hit  = we && (waddr == w_ra);
        assign w_live = addr_ok(w_ra) && !is_zero(w_ra);

        assign rdata[g*WIDTH +: WIDTH] = !w_live ? '0 : (w_hit ? wdata : r_rf[w_ra]);
        assign rbusy[g]                = w_live && r_pend[w_ra] && !w_hit;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_scb.sv
// ============================================================================
// Module   : tb_regfile_scb
// Brief    : Directed vector table plus hand sequences for regfile_scb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scb;

    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
    localparam int CW    = 6;
    localparam int NVEC  = 16;

    logic                 clk;
    logic                 rst;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    logic [NRD-1:0]       rbusy;
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [WIDTH-1:0]     wdata;
    logic                 issue;
    logic [AW-1:0]        iaddr;
    logic                 issue_ok;
    logic [CW-1:0]        pend_cnt;

    int n_checks;
    int n_fail;

    regfile_scb #(
        .WIDTH    (WIDTH),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .issue    (issue),
        .iaddr    (iaddr),
        .issue_ok (issue_ok),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        issue;
        logic [4:0]  iaddr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_busy;
        logic        e_ok;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic is, input logic [4:0] ia,
                         input logic [4:0] r0, input logic [4:0] r1);
        we    = w;
        waddr = wa;
        wdata = wd;
        issue = is;
        iaddr = ia;
        raddr = {r1, r0};
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

        //           we  waddr  wdata          iss  iaddr  ra0    ra1    rd0            rd1            busy   ok    cnt
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,         32'h0,         2'b00, 1'b1, 6'd0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF,  32'h0,         2'b00, 1'b1, 6'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF,  32'h0,         2'b00, 1'b1, 6'd0};
        vecs[3]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF,  32'h12345678,  2'b00, 1'b1, 6'd0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd7,  32'h0,         32'h12345678,  2'b00, 1'b1, 6'd1};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd3,  5'd5,  32'h0,         32'hDEADBEEF,  2'b01, 1'b0, 6'd1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd5,  32'h0,         32'hDEADBEEF,  2'b01, 1'b0, 6'd1};
        vecs[7]  = '{1'b1, 5'd3,  32'hAAAA5555, 1'b1, 5'd3,  5'd3,  5'd5,  32'hAAAA5555,  32'hDEADBEEF,  2'b00, 1'b1, 6'd1};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd3,  5'd7,  32'hAAAA5555,  32'h12345678,  2'b01, 1'b0, 6'd1};
        vecs[9]  = '{1'b1, 5'd3,  32'h11112222, 1'b0, 5'd3,  5'd3,  5'd3,  32'h11112222,  32'h11112222,  2'b00, 1'b1, 6'd0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  5'd3,  5'd0,  32'h11112222,  32'h0,         2'b00, 1'b1, 6'd0};
        vecs[11] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 1'b1, 6'd0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd5,  32'h0,         32'hDEADBEEF,  2'b00, 1'b1, 6'd0};
        vecs[13] = '{1'b1, 5'd3,  32'h33333333, 1'b1, 5'd10, 5'd10, 5'd3,  32'h0,         32'h33333333,  2'b00, 1'b1, 6'd1};
        vecs[14] = '{1'b1, 5'd10, 32'hA0A0A0A0, 1'b1, 5'd11, 5'd10, 5'd11, 32'hA0A0A0A0,  32'h0,         2'b00, 1'b1, 6'd1};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd11, 5'd10, 5'd11, 32'hA0A0A0A0,  32'h0,         2'b10, 1'b0, 6'd1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd31);
        #2;
        check("reset_rdata", rdata[31:0] | rdata[63:32], 32'h0);
        check("reset_rbusy", {30'd0, rbusy}, 32'h0);
        check("reset_issue_ok", {31'd0, issue_ok}, 32'h1);
        check("reset_pend_cnt", {26'd0, pend_cnt}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].issue, vecs[i].iaddr,
                  vecs[i].ra0, vecs[i].ra1);
            #2;
            check($sformatf("v%0d_rdata0", i), rdata[31:0], vecs[i].e_rd0);
            check($sformatf("v%0d_rdata1", i), rdata[63:32], vecs[i].e_rd1);
            check($sformatf("v%0d_rbusy", i), {30'd0, rbusy}, {30'd0, vecs[i].e_busy});
            check($sformatf("v%0d_issue_ok", i), {31'd0, issue_ok}, {31'd0, vecs[i].e_ok});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pend_cnt", i), {26'd0, pend_cnt}, {26'd0, vecs[i].e_cnt});
        end

        // Register 11 is already pending; three more issues bring the count to 4.
        for (int r = 12; r <= 14; r++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'd5, 5'd11);
            @(posedge clk);
            #1;
        end
        check("seq_pend_cnt_4", {26'd0, pend_cnt}, 32'd4);

        // Asynchronous reset between edges.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd11, 5'd5, 5'd10);
        #2;
        check("pre_rst_rdata0", rdata[31:0], 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("async_rst_pend_cnt", {26'd0, pend_cnt}, 32'h0);
        check("async_rst_rdata0", rdata[31:0], 32'h0);
        check("async_rst_rdata1", rdata[63:32], 32'h0);
        raddr = {5'd11, 5'd12};
        #1;
        check("async_rst_rbusy", {30'd0, rbusy}, 32'h0);
        check("async_rst_issue_ok", {31'd0, issue_ok}, 32'h1);

        // Write and issue presented during reset must be discarded.
        drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b1, 5'd6, 5'd5, 5'd6);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd5, 5'd6);
        #1;
        check("rst_edge_rdata0", rdata[31:0], 32'h0);
        check("rst_edge_pend_cnt", {26'd0, pend_cnt}, 32'h0);
        check("rst_edge_issue_ok", {31'd0, issue_ok}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("post_rst_rbusy", {30'd0, rbusy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
